// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   ALUOP_RTYPE   : main-control op class that carries an MDU funct
//   F_*           : R-type funct codes handled by the unit
//   mdu_state_e   : controller FSM state encoding
//   funct_ok()    : decode of the funct codes this build accepts
// Build option: MDU_DIV_EN -- when defined, div/divu are accepted;
// otherwise they decode as illegal.
package mdu_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic funct_ok(input logic [5:0] f);
    logic ok;
    case (f)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU: ok = 1'b1;
`ifdef MDU_DIV_EN
      F_DIV, F_DIVU: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter -- one iteration step of the MDU datapath (pure combinational).
//   acc      : upper working register (partial product / partial remainder)
//   q        : lower working register (multiplier bits / dividend-quotient)
//   b        : multiplicand or divisor magnitude
//   div_mode : (MDU_DIV_EN builds only) 1 = restoring-divide step
//   acc_nxt, q_nxt : register values after this step
// Multiply step: if q[0], acc += b; then {carry,acc,q} shifts right one bit.
// Divide step:   shift {acc,q} left one bit, trial-subtract b from the
// shifted remainder, keep it and shift in a 1 if there was no borrow.
// A single XLEN+1 bit adder serves both steps.
// Build option: MDU_DIV_EN adds the divide step and the div_mode port.
module mdu_iter #(
  parameter int XLEN = 32
) (
`ifdef MDU_DIV_EN
  input  logic            div_mode,
`endif
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] q_nxt
);

`ifdef MDU_DIV_EN
  logic [XLEN:0]   opa;
  logic [XLEN:0]   opb;
  logic            cin;
  logic [XLEN+1:0] sum;

  always_comb begin
    if (div_mode) begin
      // subtract via a + ~b + 1; the extra top bit of sum is the no-borrow flag
      opa = {acc, q[XLEN-1]};
      opb = ~{1'b0, b};
      cin = 1'b1;
    end else begin
      opa = {1'b0, acc};
      opb = q[0] ? {1'b0, b} : '0;
      cin = 1'b0;
    end
  end

  assign sum = {1'b0, opa} + {1'b0, opb} + {{(XLEN+1){1'b0}}, cin};

  always_comb begin
    if (div_mode) begin
      if (sum[XLEN+1]) begin
        acc_nxt = sum[XLEN-1:0];
        q_nxt   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = opa[XLEN-1:0];
        q_nxt   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[XLEN:1];
      q_nxt   = {sum[0], q[XLEN-1:1]};
    end
  end
`else
  logic [XLEN:0] sum;

  assign sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
  assign acc_nxt = sum[XLEN:1];
  assign q_nxt   = {sum[0], q[XLEN-1:1]};
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- iterative multiply/divide unit with architectural HI/LO.
//   clk, reset     : clock, synchronous active-high reset
//   start          : request strobe, looked at only in IDLE
//   aluop, funct   : op class (must be R-type) and MDU function code
//   rs_val, rt_val : operands (rs also feeds mthi/mtlo)
//   busy           : an accepted operation is in MUL, DIV or DONE
//   done           : one-cycle pulse while in DONE
//   illegal        : one-cycle pulse after a rejected request
//   hi, lo         : HI/LO registers
//   dbg_state      : current FSM state (mdu_state_e encoding)
// Handshake: a request is taken on the rising edge where start=1 and the
// unit is IDLE; busy is high from the next cycle until DONE returns to
// IDLE, and start is ignored (not queued) while busy.
// Signed ops run on magnitudes; the result is negated at the DONE-entry
// edge, so HI/LO only ever show final values.
// Build option: MDU_DIV_EN compiles in the divide path and DIV state.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      aluop,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN) + 1;

  mdu_state_e        state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   qr;
  logic [XLEN-1:0]   opb;
  logic              neg_p;    // negate product / quotient at the end
`ifdef MDU_DIV_EN
  logic              neg_r;    // negate remainder (dividend was negative)
`endif

  logic [XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]   q_nxt;
  logic              sgn;
  logic              last;
  logic [2*XLEN-1:0] prod;

  // even funct codes (mult, div) are the signed variants
  assign sgn  = ~funct[0];
  assign last = (cnt == CW'(XLEN - 1));
  assign prod = {acc_nxt, q_nxt};

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                          input logic s);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction

  mdu_iter #(.XLEN(XLEN)) u_iter (
`ifdef MDU_DIV_EN
    .div_mode (state == S_DIV),
`endif
    .acc      (acc),
    .q        (qr),
    .b        (opb),
    .acc_nxt  (acc_nxt),
    .q_nxt    (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      qr      <= '0;
      opb     <= '0;
      neg_p   <= 1'b0;
`ifdef MDU_DIV_EN
      neg_r   <= 1'b0;
`endif
      hi      <= '0;
      lo      <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (aluop != ALUOP_RTYPE || !funct_ok(funct)) begin
              illegal <= 1'b1;
            end else begin
              cnt   <= '0;
              acc   <= '0;
              qr    <= mag(rs_val, sgn);
              opb   <= mag(rt_val, sgn);
              neg_p <= sgn & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
              state <= S_DONE;
              case (funct)
                F_MULT, F_MULTU: state <= S_MUL;
`ifdef MDU_DIV_EN
                F_DIV, F_DIVU: begin
                  neg_r <= sgn & rs_val[XLEN-1];
                  if (rt_val == '0) begin
                    // divide by zero: fixed result, no iterations
                    lo <= '1;
                    hi <= rs_val;
                  end else begin
                    state <= S_DIV;
                  end
                end
`endif
                F_MTHI:  hi <= rs_val;
                F_MTLO:  lo <= rs_val;
                default: ;  // mfhi/mflo: nothing to update
              endcase
            end
          end
        end
        S_MUL: begin
          acc <= acc_nxt;
          qr  <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            {hi, lo} <= neg_p ? -prod : prod;
            state    <= S_DONE;
          end
        end
`ifdef MDU_DIV_EN
        S_DIV: begin
          acc <= acc_nxt;
          qr  <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            // |most-negative| / 1 yields most-negative again after negation
            lo    <= neg_p ? -q_nxt : q_nxt;
            hi    <= neg_r ? -acc_nxt : acc_nxt;
            state <= S_DONE;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- directed self-checking bench for mdu_ctrl (XLEN=32).
// Latency is counted in cycles after the accepting edge: cycle 1 is the
// first cycle after the edge where start was sampled.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [1:0]      aluop;
  logic [5:0]      funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model_hi = '0;
  logic [XLEN-1:0] model_lo = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mdu_ctrl #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .aluop     (aluop),
    .funct     (funct),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(posedge clk); #1;
    start  = 1'b1;
    aluop  = op;
    funct  = f;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;   // accepting edge; now in cycle 1
    start  = 1'b0;
  endtask

  // Advance until done or a cycle budget runs out; lat_in is the current cycle.
  task automatic wait_done(input int lat_in, output int lat, output bit ill_seen);
    lat      = lat_in;
    ill_seen = 1'b0;
    while (!done && lat < 60) begin
      ill_seen |= illegal;
      @(posedge clk); #1;
      lat++;
    end
    ill_seen |= illegal;
  endtask

  task automatic finish_op(input string tag, input int lat, input bit ill,
                           input int exp_lat);
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " done"}, done, 1);
    check_eq({tag, " no illegal"}, ill, 0);
    check_eq({tag, " hi"}, hi, exp_q.pop_front());
    check_eq({tag, " lo"}, lo, exp_q.pop_front());
    @(posedge clk); #1;
    check_eq({tag, " back to idle"}, busy, 0);
    check_eq({tag, " done pulse ends"}, done, 0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int exp_lat, input logic [XLEN-1:0] exp_hi,
                        input logic [XLEN-1:0] exp_lo);
    int lat;
    bit ill;
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
    issue(ALUOP_RTYPE, f, a, b);
    check_eq({tag, " busy"}, busy, 1);
    wait_done(1, lat, ill);
    finish_op(tag, lat, ill, exp_lat);
  endtask

  task automatic run_illegal(input string tag, input logic [1:0] op,
                             input logic [5:0] f, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b);
    issue(op, f, a, b);
    check_eq({tag, " illegal"}, illegal, 1);
    check_eq({tag, " busy"}, busy, 0);
    check_eq({tag, " done"}, done, 0);
    check_eq({tag, " hi kept"}, hi, model_hi);
    check_eq({tag, " lo kept"}, lo, model_lo);
    @(posedge clk); #1;
    check_eq({tag, " illegal pulse ends"}, illegal, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit ill;
    int done_cnt;

    reset  = 1'b1;
    start  = 1'b0;
    aluop  = '0;
    funct  = '0;
    rs_val = '0;
    rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    check_eq("reset illegal", illegal, 0);
    check_eq("reset hi", hi, 0);
    check_eq("reset lo", lo, 0);
    check_eq("reset state", dbg_state, 0);
    reset = 1'b0;

    // -3 * 7 = -21
    run_op("mult neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    // (2^32-1)^2 = 0xFFFFFFFE_00000001
    run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    // -2 * -3 = 6
    run_op("mult negneg", F_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32'h0, 32'h6);
    run_op("mthi", F_MTHI, 32'hA5A5_A5A5, 32'h0, 1, 32'hA5A5_A5A5, 32'h6);
    run_op("mtlo", F_MTLO, 32'h3C3C_3C3C, 32'h0, 1, 32'hA5A5_A5A5, 32'h3C3C_3C3C);
    run_op("mfhi", F_MFHI, 32'h1111_1111, 32'h2222_2222, 1, 32'hA5A5_A5A5, 32'h3C3C_3C3C);
    run_op("mflo", F_MFLO, 32'h3333_3333, 32'h4444_4444, 1, 32'hA5A5_A5A5, 32'h3C3C_3C3C);
    run_illegal("bad aluop", 2'b00, F_MULT, 32'h5, 32'h6);

    // start held during a multu must be ignored: 0x12345678 * 0x10
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h2345_6780);
    model_hi = 32'h0000_0001;
    model_lo = 32'h2345_6780;
    issue(ALUOP_RTYPE, F_MULTU, 32'h1234_5678, 32'h10);
    check_eq("busy ignore busy", busy, 1);
    start  = 1'b1;
    funct  = F_MTHI;
    rs_val = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("busy ignore no illegal", illegal, 0);
    end
    start = 1'b0;
    wait_done(4, lat, ill);
    finish_op("busy ignore multu", lat, ill, 33);

`ifdef MDU_DIV_EN
    // -7 / 2 = -3 rem -1
    run_op("div neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div minneg", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    run_op("divu by zero", F_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
    // 100 / 7 = 14 rem 2
    run_op("divu", F_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
`else
    run_illegal("divu disabled", ALUOP_RTYPE, F_DIVU, 32'd5, 32'd0);
    run_illegal("div disabled", ALUOP_RTYPE, F_DIV, 32'd9, 32'd3);
`endif

    // reset in cycle 10 of a mult aborts it with no done
    issue(ALUOP_RTYPE, F_MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check_eq("abort busy before reset", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check_eq("abort busy", busy, 0);
    check_eq("abort done", done, 0);
    check_eq("abort hi", hi, 0);
    check_eq("abort lo", lo, 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    check_eq("abort no done pulse", done_cnt, 0);
    run_illegal("funct 100000", ALUOP_RTYPE, 6'b100000, 32'h7, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
